cnf_loader: RTL and testbench
=============================

Name: cnf_loader

Overview:
- Host-side driver for the lookup top level. Receives a typed word stream from the host and sequences it into the top-level load ports: node_in, dummy_ptr, change_eng and mem2uca/mem2uca_done.
- Holds halt while loading, releases it for the BCP run, and monitors conflict/stall.
- On stall, drains the assignment stack through mstack_pop/mstack_lit into a result stream.

Parameters:
- NUM_ENGINE, `NUM_ENGINE, number of engines to load; the final engine has no trailing ENG_SWITCH.
- MAX_RUN_CYCLES, 32'd1_000_000, run-phase timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- host_valid  in  1  host word valid
- host_ready  out  1  loader accepts host word
- host_type  in  3  hword_t: CLAUSE, PTR, ENG_SWITCH, UNIT, END
- host_data  in  $bits(node_t)  payload; PTR uses the low $bits(dummy_entry_t) bits, UNIT uses the low $bits(lit_t) bits
- node_in  out  node_t  clause node to top
- node_in_valid  out  1  one-cycle push
- dummy_ptr  out  dummy_entry_t  pointer to top
- dummy_ptr_valid  out  1  one-cycle push
- change_eng  out  1  one-cycle engine advance
- mem2uca  out  lit_t  initial unit literal
- mem2uca_valid  out  1  one-cycle push
- mem2uca_done  out  1  one-cycle end-of-units pulse
- halt  out  1  halt to top
- conflict  in  1  from top
- stall  in  1  from top
- mstack_empty  in  1  from top
- mstack_lit  in  lit_t  head of stack; valid while !mstack_empty
- mstack_pop  out  1  pop request
- res_lit  out  lit_t  drained literal
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- busy  out  1  state != IDLE/DONE/ERR
- status  out  2  0 NONE, 1 SAT_PARTIAL, 2 UNSAT, 3 ERROR; held until next start
- run_cycles  out  32  saturating cycle count of the RUN phase

Behaviour:
- Reset: state=IDLE, halt=1; all valid, pulse and pop outputs 0; payload outputs 0; status=0, run_cycles=0, eng_cnt=0, host_ready=0.
- Host stream: a word transfers when host_valid && host_ready.
  - host_ready=1 only in LOAD_CLA, LOAD_PTR and LOAD_UC.
  - One word per cycle.
  - Every output is registered: 1-cycle latency from transfer to the pulse. Pulses never extend past one cycle.
- FSM:
  - IDLE --start--> LOAD_CLA. Clears status, run_cycles and eng_cnt.
  - LOAD_CLA:
    - CLAUSE emits node_in_valid.
    - PTR emits dummy_ptr_valid and moves to LOAD_PTR.
    - UNIT emits mem2uca_valid and moves to LOAD_UC.
    - END emits mem2uca_done and moves to RUN.
    - ENG_SWITCH moves to ERR.
  - LOAD_PTR:
    - PTR emits dummy_ptr_valid.
    - ENG_SWITCH: if eng_cnt < NUM_ENGINE-1, emits change_eng, increments eng_cnt and moves to LOAD_CLA; otherwise moves to ERR.
    - UNIT and END behave as in LOAD_CLA.
    - CLAUSE moves to ERR.
  - LOAD_UC:
    - UNIT emits mem2uca_valid.
    - END emits mem2uca_done and moves to RUN.
    - Any other type moves to ERR.
  - RUN:
    - halt=0; run_cycles increments and saturates at all-ones.
    - conflict moves to DONE with status=2. conflict has priority over stall in the same cycle.
    - stall (with no conflict) moves to DRAIN.
    - run_cycles == MAX_RUN_CYCLES moves to ERR.
    - Evaluation starts the cycle after entry, so the mem2uca_done pulse has already left.
  - DRAIN:
    - halt=1.
    - mstack_pop = !mstack_empty && (!res_valid || res_ready). On pop, res_lit<=mstack_lit and res_valid<=1.
    - res_valid clears on res_ready when no new pop occurs that cycle.
    - mstack_empty && !res_valid moves to DONE with status=1.
  - DONE: halt=1. start moves to LOAD_CLA, clearing status, run_cycles and eng_cnt.
  - ERR: halt=1, status=3. Only reset or start leaves ERR.
- start outside IDLE, DONE or ERR is ignored.
- Reset asserted mid-operation forces the reset values immediately. In-flight pulses are dropped; the host must restart.

Decomposition:
- Package lookup_pkg:
  - hword_t enum (CLAUSE=0, PTR=1, ENG_SWITCH=2, UNIT=3, END=4).
  - loader_state_t.
  - Status encodings.
  - Reuse of the existing node_t, dummy_entry_t, lit_t and `NUM_ENGINE.
- One sub-module, loader_result_skid: the 1-entry result register with pop/ready logic used in DRAIN.

Test Plan:
- NUM_ENGINE=2; stream CLAUSE×3, PTR×2, ENG_SWITCH, CLAUSE×2, PTR, UNIT 5, UNIT 9, END → node_in_valid pulses 3+2, dummy_ptr_valid 2+1, one change_eng, mem2uca_valid carrying 5 then 9, then one mem2uca_done; halt falls the cycle after.
- Second ENG_SWITCH with NUM_ENGINE=2 → status=3, host_ready=0, no change_eng pulse.
- RUN with conflict and stall raised in the same cycle → status=2, state DONE, no mstack_pop.
- Stall with the stack holding lits 7, 3, 12 and res_ready toggling 1,0,1,1 → res_lit 7, 3, 12 in order; no pop while res_valid && !res_ready; status=1.
- MAX_RUN_CYCLES=10 with no conflict or stall → ERR after exactly 10 run cycles; run_cycles=10.
- rst_n asserted in LOAD_UC mid-stream → all outputs return to reset values asynchronously; after release, start reloads cleanly.

Source files
------------

// File: rtl/lookup_pkg.sv
// Shared types for the lookup top level and its host-side loader.
// Literal, node and dummy-pointer formats plus loader word/state/status encodings.
`ifndef NUM_ENGINE
`define NUM_ENGINE 2
`endif

package lookup_pkg;

  typedef logic [15:0] lit_t;
  typedef logic [9:0]  dummy_entry_t;

  typedef struct packed {
    lit_t       lit;
    logic [8:0] next;
    logic       last;
  } node_t;

  typedef enum logic [2:0] {
    CLAUSE     = 3'd0,
    PTR        = 3'd1,
    ENG_SWITCH = 3'd2,
    UNIT       = 3'd3,
    END        = 3'd4
  } hword_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_CLA, S_LOAD_PTR, S_LOAD_UC, S_RUN, S_DRAIN, S_DONE, S_ERR
  } loader_state_t;

  localparam logic [1:0] ST_NONE        = 2'd0;
  localparam logic [1:0] ST_SAT_PARTIAL = 2'd1;
  localparam logic [1:0] ST_UNSAT       = 2'd2;
  localparam logic [1:0] ST_ERROR       = 2'd3;

endpackage

// File: rtl/loader_result_skid.sv
// One-entry result register between the assignment stack and the result consumer.
module loader_result_skid
  import lookup_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic mstack_empty,
  input  lit_t mstack_lit,
  input  logic res_ready,
  output logic mstack_pop,
  output lit_t res_lit,
  output logic res_valid
);

  // pop only when the slot is free or being emptied this cycle
  assign mstack_pop = en && !mstack_empty && (!res_valid || res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_lit   <= '0;
    end else if (mstack_pop) begin
      res_valid <= 1'b1;
      res_lit   <= mstack_lit;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cnf_loader.sv
// Host-side loader: sequences a typed host word stream into the lookup top level,
// runs BCP with halt released, then drains the assignment stack on stall.
`ifndef NUM_ENGINE
`define NUM_ENGINE 2
`endif

module cnf_loader
  import lookup_pkg::*;
#(
  parameter int          NUM_ENGINE     = `NUM_ENGINE,
  parameter logic [31:0] MAX_RUN_CYCLES = 32'd1_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      host_valid,
  output logic                      host_ready,
  input  logic [2:0]                host_type,
  input  logic [$bits(node_t)-1:0]  host_data,
  output node_t                     node_in,
  output logic                      node_in_valid,
  output dummy_entry_t              dummy_ptr,
  output logic                      dummy_ptr_valid,
  output logic                      change_eng,
  output lit_t                      mem2uca,
  output logic                      mem2uca_valid,
  output logic                      mem2uca_done,
  output logic                      halt,
  input  logic                      conflict,
  input  logic                      stall,
  input  logic                      mstack_empty,
  input  lit_t                      mstack_lit,
  output logic                      mstack_pop,
  output lit_t                      res_lit,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      busy,
  output logic [1:0]                status,
  output logic [31:0]               run_cycles
);

  localparam int ENG_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int LW    = $bits(lit_t);
  localparam int DW    = $bits(dummy_entry_t);

  loader_state_t state, nxt_state;
  logic [1:0]    nxt_status;
  logic [ENG_W-1:0] eng_cnt;
  logic xfer, clear;
  logic emit_node, emit_ptr, emit_eng, emit_unit, emit_done;

  assign host_ready = (state == S_LOAD_CLA) || (state == S_LOAD_PTR) || (state == S_LOAD_UC);
  assign busy       = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign xfer       = host_valid && host_ready;

  always_comb begin
    nxt_state  = state;
    nxt_status = status;
    clear      = 1'b0;
    emit_node  = 1'b0;
    emit_ptr   = 1'b0;
    emit_eng   = 1'b0;
    emit_unit  = 1'b0;
    emit_done  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (start) begin
          nxt_state  = S_LOAD_CLA;
          nxt_status = ST_NONE;
          clear      = 1'b1;
        end
      S_LOAD_CLA, S_LOAD_PTR:
        if (xfer) begin
          case (host_type)
            CLAUSE:
              if (state == S_LOAD_CLA) emit_node = 1'b1;
              else begin nxt_state = S_ERR; nxt_status = ST_ERROR; end
            PTR: begin
              emit_ptr  = 1'b1;
              nxt_state = S_LOAD_PTR;
            end
            ENG_SWITCH:
              if (state == S_LOAD_PTR && eng_cnt < ENG_W'(NUM_ENGINE - 1)) begin
                emit_eng  = 1'b1;
                nxt_state = S_LOAD_CLA;
              end else begin
                nxt_state  = S_ERR;
                nxt_status = ST_ERROR;
              end
            UNIT: begin
              emit_unit = 1'b1;
              nxt_state = S_LOAD_UC;
            end
            END: begin
              emit_done = 1'b1;
              nxt_state = S_RUN;
            end
            default: begin nxt_state = S_ERR; nxt_status = ST_ERROR; end
          endcase
        end
      S_LOAD_UC:
        if (xfer) begin
          case (host_type)
            UNIT:    emit_unit = 1'b1;
            END:     begin emit_done = 1'b1; nxt_state = S_RUN; end
            default: begin nxt_state = S_ERR; nxt_status = ST_ERROR; end
          endcase
        end
      S_RUN:
        if (conflict) begin
          nxt_state  = S_DONE;
          nxt_status = ST_UNSAT;
        end else if (stall) begin
          nxt_state = S_DRAIN;
        end else if (run_cycles == MAX_RUN_CYCLES) begin
          nxt_state  = S_ERR;
          nxt_status = ST_ERROR;
        end
      S_DRAIN:
        if (mstack_empty && !res_valid) begin
          nxt_state  = S_DONE;
          nxt_status = ST_SAT_PARTIAL;
        end
      default: begin nxt_state = S_ERR; nxt_status = ST_ERROR; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      status          <= ST_NONE;
      run_cycles      <= '0;
      eng_cnt         <= '0;
      halt            <= 1'b1;
      node_in         <= '0;
      node_in_valid   <= 1'b0;
      dummy_ptr       <= '0;
      dummy_ptr_valid <= 1'b0;
      change_eng      <= 1'b0;
      mem2uca         <= '0;
      mem2uca_valid   <= 1'b0;
      mem2uca_done    <= 1'b0;
    end else begin
      state           <= nxt_state;
      status          <= nxt_status;
      // halt drops one cycle after RUN entry, after mem2uca_done has gone out
      halt            <= !(state == S_RUN && nxt_state == S_RUN);
      node_in_valid   <= emit_node;
      dummy_ptr_valid <= emit_ptr;
      change_eng      <= emit_eng;
      mem2uca_valid   <= emit_unit;
      mem2uca_done    <= emit_done;
      if (emit_node) node_in   <= node_t'(host_data);
      if (emit_ptr)  dummy_ptr <= host_data[DW-1:0];
      if (emit_unit) mem2uca   <= host_data[LW-1:0];
      if (clear) begin
        run_cycles <= '0;
        eng_cnt    <= '0;
      end else begin
        if (emit_eng) eng_cnt <= eng_cnt + ENG_W'(1);
        if (state == S_RUN && nxt_state == S_RUN && run_cycles != '1)
          run_cycles <= run_cycles + 32'd1;
      end
    end
  end

  loader_result_skid u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (state == S_DRAIN),
    .mstack_empty (mstack_empty),
    .mstack_lit   (mstack_lit),
    .res_ready    (res_ready),
    .mstack_pop   (mstack_pop),
    .res_lit      (res_lit),
    .res_valid    (res_valid)
  );

endmodule

// File: tb/tb_cnf_loader.sv
// Directed bench for cnf_loader: host stream load, error paths, conflict, drain, timeout, reset.
module tb_cnf_loader;
  import lookup_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, host_valid = 1'b0, host_ready;
  logic [2:0] host_type = 3'd0;
  logic [25:0] host_data = '0;
  node_t node_in;
  logic node_in_valid, dummy_ptr_valid, change_eng, mem2uca_valid, mem2uca_done, halt;
  dummy_entry_t dummy_ptr;
  lit_t mem2uca, mstack_lit, res_lit;
  logic conflict = 1'b0, stall = 1'b0, res_ready = 1'b0;
  logic mstack_empty, mstack_pop, res_valid, busy;
  logic [1:0] status;
  logic [31:0] run_cycles;

  always #5 clk = ~clk;

  cnf_loader #(.NUM_ENGINE(2), .MAX_RUN_CYCLES(32'd10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .host_valid(host_valid), .host_ready(host_ready),
    .host_type(host_type), .host_data(host_data), .node_in(node_in), .node_in_valid(node_in_valid),
    .dummy_ptr(dummy_ptr), .dummy_ptr_valid(dummy_ptr_valid), .change_eng(change_eng),
    .mem2uca(mem2uca), .mem2uca_valid(mem2uca_valid), .mem2uca_done(mem2uca_done), .halt(halt),
    .conflict(conflict), .stall(stall), .mstack_empty(mstack_empty), .mstack_lit(mstack_lit),
    .mstack_pop(mstack_pop), .res_lit(res_lit), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .status(status), .run_cycles(run_cycles)
  );

  int total = 0, bad = 0;
  int n_node = 0, n_ptr = 0, n_eng = 0, n_unit = 0, n_done = 0, n_pop = 0, n_res = 0;
  logic [25:0] q_node[$];
  logic [9:0]  q_ptr[$];
  logic [15:0] q_unit[$], q_res[$];
  logic prev_done = 1'b0;

  // assignment stack model
  lit_t stk_mem [0:2];
  int stk_len = 0, sp = 0;
  assign mstack_empty = (sp >= stk_len);
  assign mstack_lit   = (sp < 3) ? stk_mem[sp] : '0;
  always @(posedge clk) if (mstack_pop) sp <= sp + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // output monitor, sampled mid-low-phase after inputs settle
  always @(negedge clk) begin
    #2;
    if (!rst_n) prev_done = 1'b0;
    else begin
      if (node_in_valid) begin
        n_node++;
        if (q_node.size() == 0) chk("node_unexp", 32'(node_in_valid), 0);
        else chk("node_in", 32'(node_in), 32'(q_node.pop_front()));
      end
      if (dummy_ptr_valid) begin
        n_ptr++;
        if (q_ptr.size() == 0) chk("ptr_unexp", 32'(dummy_ptr_valid), 0);
        else chk("dummy_ptr", 32'(dummy_ptr), 32'(q_ptr.pop_front()));
      end
      if (mem2uca_valid) begin
        n_unit++;
        if (q_unit.size() == 0) chk("unit_unexp", 32'(mem2uca_valid), 0);
        else chk("mem2uca", 32'(mem2uca), 32'(q_unit.pop_front()));
      end
      if (res_valid && res_ready) begin
        n_res++;
        if (q_res.size() == 0) chk("res_unexp", 32'(res_valid), 0);
        else chk("res_lit", 32'(res_lit), 32'(q_res.pop_front()));
      end
      if (res_valid && !res_ready) chk("pop_hold", 32'(mstack_pop), 0);
      if (change_eng) n_eng++;
      if (mstack_pop) n_pop++;
      if (prev_done) chk("halt_fall", 32'(halt), 0);
      if (mem2uca_done) begin
        n_done++;
        chk("halt_at_done", 32'(halt), 1);
      end
      prev_done = mem2uca_done;
    end
  end

  task automatic send(input logic [2:0] t, input logic [25:0] d);
    int n = 0;
    @(negedge clk);
    host_type = t; host_data = d; host_valid = 1'b1;
    while (!host_ready && n < 20) begin @(negedge clk); n++; end
    if (!host_ready) chk("send_timeout", 32'(host_ready), 1);
    else @(posedge clk);
    #1 host_valid = 1'b0;
  endtask

  task automatic send_cla(input logic [25:0] d);
    q_node.push_back(d); send(CLAUSE, d);
  endtask
  task automatic send_ptr(input logic [9:0] p);
    q_ptr.push_back(p); send(PTR, {16'h0, p});
  endtask
  task automatic send_unit(input logic [15:0] l);
    q_unit.push_back(l); send(UNIT, {10'h0, l});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    chk("wait_idle", 32'(busy), 0);
  endtask

  initial begin
    stk_mem[0] = 16'd7; stk_mem[1] = 16'd3; stk_mem[2] = 16'd12;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_halt", 32'(halt), 1);
    chk("rst_ready", 32'(host_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_runc", run_cycles, 0);
    chk("rst_pop", 32'(mstack_pop), 0);
    chk("rst_resv", 32'(res_valid), 0);
    #18 rst_n = 1'b1;

    // full two-engine load
    pulse_start();
    chk("ld_ready", 32'(host_ready), 1);
    chk("ld_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) send_cla(26'h100000 + 26'(i * 37));
    send_ptr(10'h011); send_ptr(10'h022);
    send(ENG_SWITCH, 26'h0);
    send_cla(26'h2abcde); send_cla(26'h3fffff);
    send_ptr(10'h3a5);
    send_unit(16'd5); send_unit(16'd9);
    send(END, 26'h0);
    wait_cyc(3);
    chk("s1_node", n_node, 5);
    chk("s1_ptr", n_ptr, 3);
    chk("s1_eng", n_eng, 1);
    chk("s1_unit", n_unit, 2);
    chk("s1_done", n_done, 1);
    chk("s1_run_halt", 32'(halt), 0);
    chk("s1_run_ready", 32'(host_ready), 0);

    // conflict and stall together: conflict wins
    @(negedge clk) begin conflict = 1'b1; stall = 1'b1; end
    @(negedge clk) begin conflict = 1'b0; stall = 1'b0; end
    wait_cyc(2);
    chk("cf_status", 32'(status), 2);
    chk("cf_busy", 32'(busy), 0);
    chk("cf_halt", 32'(halt), 1);
    chk("cf_pop", n_pop, 0);

    // second ENG_SWITCH with two engines is an error
    pulse_start();
    chk("rs_status", 32'(status), 0);
    send_cla(26'h000123); send_ptr(10'h044);
    send(ENG_SWITCH, 26'h0);
    send_cla(26'h000456); send_ptr(10'h055);
    send(ENG_SWITCH, 26'h0);
    wait_cyc(2);
    chk("es_eng", n_eng, 2);
    chk("es_status", 32'(status), 3);
    chk("es_ready", 32'(host_ready), 0);
    chk("es_halt", 32'(halt), 1);

    // stall and drain 7,3,12 with res_ready 1,0,1,1
    pulse_start();
    send_unit(16'd1);
    send(END, 26'h0);
    wait_cyc(3);
    stk_len = 3;
    q_res.push_back(16'd7); q_res.push_back(16'd3); q_res.push_back(16'd12);
    @(negedge clk) begin stall = 1'b1; res_ready = 1'b1; end
    @(negedge clk) stall = 1'b0;
    #1 chk("dr_halt", 32'(halt), 1);
    @(negedge clk) res_ready = 1'b0;
    @(negedge clk) res_ready = 1'b1;
    wait_idle();
    chk("dr_status", 32'(status), 1);
    chk("dr_res", n_res, 3);
    chk("dr_pop", n_pop, 3);
    chk("dr_q", q_res.size(), 0);

    // run-phase timeout
    pulse_start();
    send_unit(16'd2);
    send(END, 26'h0);
    wait_idle();
    chk("to_status", 32'(status), 3);
    chk("to_runc", run_cycles, 10);
    chk("to_halt", 32'(halt), 1);

    // reset mid LOAD_UC, then clean reload
    pulse_start();
    send_unit(16'd4);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_state_busy", 32'(busy), 0);
    chk("mr_ready", 32'(host_ready), 0);
    chk("mr_halt", 32'(halt), 1);
    chk("mr_mem2uca", 32'(mem2uca), 0);
    chk("mr_valid", 32'(mem2uca_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    send_cla(26'h0a0a0a); send_ptr(10'h1c3); send_unit(16'd6);
    send(END, 26'h0);
    wait_cyc(3);
    chk("rl_node", n_node, 8);
    chk("rl_ptr", n_ptr, 6);
    chk("rl_unit", n_unit, 6);
    chk("rl_done", n_done, 4);
    @(negedge clk) conflict = 1'b1;
    @(negedge clk) conflict = 1'b0;
    wait_cyc(2);
    chk("rl_status", 32'(status), 2);
    chk("q_left", q_node.size() + q_ptr.size() + q_unit.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
